result_display: RTL

Downstream stage of the `uP` core: it captures the 8-bit `Output` result whenever `uP` raises `Halt` and converts it to three BCD digits with a sequential double-dabble (one shift per cycle). It then drives a time-multiplexed 3-digit 7-segment display with leading-zero blanking. It sits between `uP` and the board display pins, and its BCD bus is also available to the bench.

---
 rtl/result_display_pkg.sv | 31 +++
 rtl/result_display_bcd_dabble8.sv | 43 ++++
 rtl/result_display.sv | 112 +++++++++++
 3 files changed

// File: rtl/result_display_pkg.sv
// Shared types and helpers for the result_display block: FSM states,
// digit count, BCD correction and 7-segment encoding.
package result_display_pkg;

  typedef enum logic [1:0] {IDLE, CONVERT, SHOW} state_t;

  localparam int NUM_DIGITS = 3;

  // Double-dabble correction: a nibble of 5 or more would overflow past 9
  // after the next shift, so bias it by 3 first.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = 7'b0000000;
    endcase
  endfunction

endpackage

// File: rtl/result_display_bcd_dabble8.sv
// Iterative 8-bit binary to 3-digit BCD converter, one add-3/shift per cycle.
// done pulses on the eighth step; bcd_out is the value that step produces.
module bcd_dabble8
  import result_display_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        run,
  input  logic [7:0]  bin_in,
  output logic        done,
  output logic [11:0] bcd_out
);

  logic [7:0]  bin_q;
  logic [11:0] bcd_q;
  logic [2:0]  cnt;
  logic [11:0] fix;
  logic [19:0] sh;

  // Hundreds never exceeds 2 for 8-bit input, so fix[11] is always 0.
  assign fix     = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
  assign sh      = {fix[10:0], bin_q, 1'b0};
  assign bcd_out = sh[19:8];
  assign done    = run && (cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt   <= '0;
    end else if (start) begin
      bin_q <= bin_in;
      bcd_q <= '0;
      cnt   <= '0;
    end else if (run) begin
      bin_q <= sh[7:0];
      bcd_q <= sh[19:8];
      cnt   <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/result_display.sv
// Captures the uP result on a Halt rise, converts it to BCD and drives a
// scanned 3-digit 7-segment display with leading-zero blanking.
module result_display
  import result_display_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        Halt,
  input  logic [7:0]  Result,
  output logic [11:0] Digits,
  output logic        Valid,
  output logic        Busy,
  output logic [6:0]  Seg,
  output logic [2:0]  An
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t      state, state_nxt;
  logic        halt_d, req, start, run, done;
  logic [11:0] bcd_out;
  logic [DW-1:0] div;
  logic [1:0]  idx;
  logic [3:0]  nib;
  logic        blank;
  logic [6:0]  seg_d;

  assign req  = Halt && !halt_d;
  assign run  = (state == CONVERT);
  assign Busy = run;

  bcd_dabble8 u_dabble (
    .clk     (CLOCK),
    .rst     (RESET),
    .start   (start),
    .run     (run),
    .bin_in  (Result),
    .done    (done),
    .bcd_out (bcd_out)
  );

  // Requests arriving mid-conversion are dropped, not queued.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE, SHOW: if (req) begin
        start     = 1'b1;
        state_nxt = CONVERT;
      end
      CONVERT: if (done) state_nxt = SHOW;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state  <= IDLE;
      halt_d <= 1'b0;
      Digits <= '0;
      Valid  <= 1'b0;
    end else begin
      state  <= state_nxt;
      halt_d <= Halt;
      if (start) begin
        Valid <= 1'b0;
      end else if (done) begin
        Digits <= bcd_out;
        Valid  <= 1'b1;
      end
    end
  end

  always_comb begin
    nib   = Digits[3:0];
    blank = 1'b0;
    case (idx)
      2'd0: nib = Digits[3:0];
      2'd1: begin
        nib   = Digits[7:4];
        blank = (Digits[11:4] == 8'h00);
      end
      2'd2: begin
        nib   = Digits[11:8];
        blank = (Digits[11:8] == 4'h0);
      end
      default: blank = 1'b1;
    endcase
    seg_d = (!Valid || blank) ? 7'b0000000 : seg(nib);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      div <= '0;
      idx <= '0;
      An  <= 3'b001;
      Seg <= 7'b0000000;
    end else begin
      if (div == DW'(SCAN_DIV - 1)) begin
        div <= '0;
        idx <= (idx == 2'(NUM_DIGITS - 1)) ? 2'd0 : idx + 2'd1;
      end else begin
        div <= div + DW'(1);
      end
      An  <= 3'b001 << idx;
      Seg <= seg_d;
    end
  end

endmodule
